// File: rtl/sram_1p_march_bist_ctrl_if.sv
// BIST-side port bundle between the March controller and one RM_IHPSG13_1P macro.
interface sram_1p_march_bist_ctrl_if #(
  parameter int P_DATA_WIDTH = 64,
  parameter int P_ADDR_WIDTH = 6
);

  logic                    A_BIST_EN;
  logic                    A_BIST_MEN;
  logic                    A_BIST_WEN;
  logic                    A_BIST_REN;
  logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR;
  logic [P_DATA_WIDTH-1:0] A_BIST_DIN;
  logic [P_DATA_WIDTH-1:0] A_BIST_BM;
  logic [P_DATA_WIDTH-1:0] A_BIST_DOUT;

  // Controller side: drives the macro's BIST port, observes its read data.
  modport master (
    output A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
    output A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
    input  A_BIST_DOUT
  );

  // Macro side.
  modport slave (
    input  A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN,
    input  A_BIST_ADDR, A_BIST_DIN, A_BIST_BM,
    output A_BIST_DOUT
  );

endinterface

// File: rtl/sram_1p_march_bist_ctrl.sv
// March C- BIST engine for a single-port SRAM macro with a BIST port.
// Sequence: up(w0) up(r0,w1) up(r1,w0) down(r0,w1) down(r1,w0) up(r0),
// one operation per cycle, followed by one drain cycle so the final read
// is compared before DONE rises.
module sram_1p_march_bist_ctrl #(
  parameter int P_DATA_WIDTH = 64,
  parameter int P_ADDR_WIDTH = 6,
  parameter int P_FCNT_WIDTH = 8
) (
  input  logic                    A_CLK,
  input  logic                    A_RST,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    FAIL,
  output logic [P_ADDR_WIDTH-1:0] FAIL_ADDR,
  output logic [P_FCNT_WIDTH-1:0] FAIL_COUNT,
  sram_1p_march_bist_ctrl_if.master bist
);

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_FIN
  } state_t;

  localparam logic [P_ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [P_ADDR_WIDTH-1:0] ADDR_MIN = '0;
  localparam logic [P_FCNT_WIDTH-1:0] FCNT_MAX = '1;

  // Sequencer state: element, address and read/write phase of the
  // operation currently on the port (phase 0 = read, 1 = write).
  state_t                  state_q, state_d;
  logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                    phase_q, phase_d;

  // Registered port values and their next-cycle decode.
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    men_q, men_d;
  logic                    wen_q, wen_d;
  logic                    ren_q, ren_d;
  logic                    din_one_d;
  logic [P_DATA_WIDTH-1:0] din_q;
  logic [P_DATA_WIDTH-1:0] bm_q;

  // Compare stage: what the read issued last cycle should return.
  logic                    cmp_vld_q;
  logic                    cmp_one_q;
  logic [P_ADDR_WIDTH-1:0] cmp_addr_q;
  logic                    miscmp;

  logic                    fail_q;
  logic [P_ADDR_WIDTH-1:0] fail_addr_q;
  logic [P_FCNT_WIDTH-1:0] fail_count_q;

  logic start_ok;
  assign start_ok = START && ((state_q == S_IDLE) || (state_q == S_FIN));

  // State register: element, address counter and operation phase.
  always_ff @(posedge A_CLK) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values,
    // so the order of statements across always_ff blocks cannot matter.
    if (A_RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  // Next-state: walk each element's address range, advancing element on
  // the last operation at the terminal address.
  always_comb begin
    // NOTE: defaults first so every path assigns every output of this block;
    // a missing branch would otherwise infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (start_ok) begin
          state_d = S_M0;
          addr_d  = ADDR_MIN;
          phase_d = 1'b0;
        end
      end
      S_M0: begin
        if (addr_q == ADDR_MAX) begin
          state_d = S_M1;
          addr_d  = ADDR_MIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_M1, S_M2: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_q == ADDR_MAX) begin
            if (state_q == S_M1) begin
              state_d = S_M2;
              addr_d  = ADDR_MIN;
            end else begin
              state_d = S_M3;
              addr_d  = ADDR_MAX;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_M3, S_M4: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (addr_q == ADDR_MIN) begin
            if (state_q == S_M3) begin
              state_d = S_M4;
              addr_d  = ADDR_MAX;
            end else begin
              state_d = S_M5;
              addr_d  = ADDR_MIN;
            end
          end else begin
            addr_d = addr_q - 1'b1;
          end
        end
      end
      S_M5: begin
        if (addr_q == ADDR_MAX) begin
          state_d = S_DRAIN;
          addr_d  = ADDR_MIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode of the operation that will be on the port next cycle.
  always_comb begin
    men_d     = 1'b0;
    wen_d     = 1'b0;
    ren_d     = 1'b0;
    din_one_d = 1'b0;
    case (state_d)
      S_M0: begin
        men_d = 1'b1;
        wen_d = 1'b1;
      end
      S_M1, S_M3: begin
        men_d     = 1'b1;
        wen_d     = phase_d;
        ren_d     = !phase_d;
        din_one_d = phase_d;
      end
      S_M2, S_M4: begin
        men_d = 1'b1;
        wen_d = phase_d;
        ren_d = !phase_d;
      end
      S_M5: begin
        men_d = 1'b1;
        ren_d = 1'b1;
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d = (state_d == S_FIN);
  end

  // Output register: all port and status strobes come straight from flops.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      men_q  <= 1'b0;
      wen_q  <= 1'b0;
      ren_q  <= 1'b0;
      din_q  <= '0;
      bm_q   <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      men_q  <= men_d;
      wen_q  <= wen_d;
      ren_q  <= ren_d;
      din_q  <= {P_DATA_WIDTH{din_one_d}};
      bm_q   <= {P_DATA_WIDTH{wen_d}};
    end
  end

  // Capture expected data and address of the read the macro samples this edge.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      cmp_vld_q  <= 1'b0;
      cmp_one_q  <= 1'b0;
      cmp_addr_q <= '0;
    end else begin
      cmp_vld_q  <= ren_q;
      cmp_one_q  <= (state_q == S_M2) || (state_q == S_M4);
      cmp_addr_q <= addr_q;
    end
  end

  assign miscmp = cmp_vld_q && (bist.A_BIST_DOUT != {P_DATA_WIDTH{cmp_one_q}});

  // Result tracking: sticky fail, first failing address, saturating count.
  always_ff @(posedge A_CLK) begin
    if (A_RST) begin
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
    end else if (start_ok) begin
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
    end else if (miscmp) begin
      fail_q <= 1'b1;
      if (!fail_q) begin
        fail_addr_q <= cmp_addr_q;
      end
      if (fail_count_q != FCNT_MAX) begin
        fail_count_q <= fail_count_q + 1'b1;
      end
    end
  end

  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign FAIL       = fail_q;
  assign FAIL_ADDR  = fail_addr_q;
  assign FAIL_COUNT = fail_count_q;

  assign bist.A_BIST_EN   = busy_q;
  assign bist.A_BIST_MEN  = men_q;
  assign bist.A_BIST_WEN  = wen_q;
  assign bist.A_BIST_REN  = ren_q;
  assign bist.A_BIST_ADDR = addr_q;
  assign bist.A_BIST_DIN  = din_q;
  assign bist.A_BIST_BM   = bm_q;

endmodule

// File: tb/tb_sram_1p_march_bist_ctrl.sv
// Bench for the March C- BIST controller: behavioural SRAM with optional
// stuck-at or inverted-read faults, and a reference model that expands the
// March C- definition into an operation list and predicts the result.
module tb_sram_1p_march_bist_ctrl;

  localparam int DW = 64;
  localparam int AW = 6;
  localparam int FW = 8;
  localparam int N  = 1 << AW;
  localparam int OPS = 10 * N;

  logic          A_CLK = 1'b0;
  logic          A_RST;
  logic          START;
  logic          BUSY, DONE, FAIL;
  logic [AW-1:0] FAIL_ADDR;
  logic [FW-1:0] FAIL_COUNT;

  sram_1p_march_bist_ctrl_if #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) bist ();

  sram_1p_march_bist_ctrl #(
    .P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW), .P_FCNT_WIDTH(FW)
  ) dut (
    .A_CLK      (A_CLK),
    .A_RST      (A_RST),
    .START      (START),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .FAIL       (FAIL),
    .FAIL_ADDR  (FAIL_ADDR),
    .FAIL_COUNT (FAIL_COUNT),
    .bist       (bist)
  );

  always #5 A_CLK = ~A_CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Fault configuration: 0 none, 1 stuck-at cell bit, 2 inverted read data.
  int            fault_mode = 0;
  logic [AW-1:0] fault_addr = '0;
  int            fault_bit  = 0;
  logic          fault_val  = 1'b0;

  function automatic logic [DW-1:0] store_val(input logic [DW-1:0] d, input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = d;
    if (fault_mode == 1 && a == fault_addr) v[fault_bit] = fault_val;
    return v;
  endfunction

  function automatic logic [DW-1:0] read_val(input logic [DW-1:0] d);
    return (fault_mode == 2) ? ~d : d;
  endfunction

  // Behavioural macro: write with bit mask, registered read data.
  logic [DW-1:0] mem [N];
  always @(posedge A_CLK) begin
    if (bist.A_BIST_MEN) begin
      if (bist.A_BIST_WEN)
        mem[bist.A_BIST_ADDR] <= store_val((mem[bist.A_BIST_ADDR] & ~bist.A_BIST_BM) |
                                           (bist.A_BIST_DIN & bist.A_BIST_BM), bist.A_BIST_ADDR);
      if (bist.A_BIST_REN)
        bist.A_BIST_DOUT <= read_val(mem[bist.A_BIST_ADDR]);
    end
  end

  // Reference operation list expanded from the March C- element table.
  typedef struct {
    bit          wr;
    bit [AW-1:0] a;
    bit          one;
  } op_t;
  op_t ops[$];

  task automatic build_ops();
    int has_r [6] = '{0, 1, 1, 1, 1, 1};
    int r_one [6] = '{0, 0, 1, 0, 1, 0};
    int has_w [6] = '{1, 1, 1, 1, 1, 0};
    int w_one [6] = '{0, 1, 0, 1, 0, 0};
    int desc  [6] = '{0, 0, 0, 1, 1, 0};
    op_t o;
    ops.delete();
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        o.a = AW'((desc[e] != 0) ? (N - 1 - i) : i);
        if (has_r[e] != 0) begin o.wr = 1'b0; o.one = (r_one[e] != 0); ops.push_back(o); end
        if (has_w[e] != 0) begin o.wr = 1'b1; o.one = (w_one[e] != 0); ops.push_back(o); end
      end
    end
  endtask

  // Predicted result: replay the op list on an array with the same fault.
  bit          e_fail;
  bit [AW-1:0] e_addr;
  int          e_cnt;

  task automatic predict();
    logic [DW-1:0] m [N];
    logic [DW-1:0] exp_d, got;
    e_fail = 0; e_addr = '0; e_cnt = 0;
    for (int i = 0; i < N; i++) m[i] = '0;
    foreach (ops[k]) begin
      exp_d = ops[k].one ? {DW{1'b1}} : {DW{1'b0}};
      if (ops[k].wr) begin
        m[ops[k].a] = store_val(exp_d, ops[k].a);
      end else begin
        got = read_val(m[ops[k].a]);
        if (got !== exp_d) begin
          if (!e_fail) e_addr = ops[k].a;
          e_fail = 1;
          e_cnt++;
        end
      end
    end
    if (e_cnt > (1 << FW) - 1) e_cnt = (1 << FW) - 1;
  endtask

  // One full test from IDLE or FIN; abort_at > 0 pulses A_RST in that cycle.
  task automatic run_test(input string name, input int abort_at, input bit extra_starts);
    int  men_cnt;
    op_t o;
    logic [DW-1:0] ones;
    ones = '1;
    predict();
    repeat ($urandom_range(0, 3)) @(negedge A_CLK);
    START = 1'b1;
    @(negedge A_CLK);
    START = 1'b0;
    men_cnt = 0;
    for (int c = 1; c <= OPS + 2; c++) begin
      START = (extra_starts && (c == 5 || c == 300)) ? 1'b1 : 1'b0;
      if (c == 1) check({name, " cleared"}, {FAIL, FAIL_ADDR, FAIL_COUNT}, '0);
      if (c <= OPS) begin
        o = ops[c-1];
        check({name, " ctl"},
              {BUSY, bist.A_BIST_EN, bist.A_BIST_MEN, bist.A_BIST_WEN, bist.A_BIST_REN, DONE, bist.A_BIST_ADDR},
              {1'b1, 1'b1, 1'b1, o.wr, !o.wr, 1'b0, o.a});
        check({name, " din"}, bist.A_BIST_DIN, (o.wr && o.one) ? ones : '0);
        check({name, " bm"}, bist.A_BIST_BM, o.wr ? ones : '0);
      end else if (c == OPS + 1) begin
        check({name, " drain"},
              {BUSY, bist.A_BIST_EN, bist.A_BIST_MEN, bist.A_BIST_WEN, bist.A_BIST_REN, DONE},
              6'b110000);
      end else begin
        check({name, " fin"}, {BUSY, bist.A_BIST_EN, bist.A_BIST_MEN, DONE}, 4'b0001);
      end
      if (c == 65)  check({name, " c65"}, {bist.A_BIST_REN, bist.A_BIST_ADDR}, {1'b1, 6'd0});
      if (c == 66)  check({name, " c66"}, {bist.A_BIST_WEN, bist.A_BIST_ADDR, bist.A_BIST_DIN},
                          {1'b1, 6'd0, ones});
      if (c == 321) check({name, " c321"}, {bist.A_BIST_REN, bist.A_BIST_ADDR}, {1'b1, 6'd63});
      if (c == 640) check({name, " c640"}, {bist.A_BIST_REN, bist.A_BIST_ADDR}, {1'b1, 6'd63});
      if (bist.A_BIST_MEN) men_cnt++;
      if (c == abort_at) begin
        A_RST = 1'b1;
        @(negedge A_CLK);
        A_RST = 1'b0;
        check({name, " abort"},
              {BUSY, bist.A_BIST_EN, bist.A_BIST_MEN, DONE, FAIL, FAIL_ADDR, FAIL_COUNT}, '0);
        return;
      end
      if (c < OPS + 2) @(negedge A_CLK);
    end
    START = 1'b0;
    check({name, " men_cnt"}, 64'(men_cnt), 64'(OPS));
    check({name, " fail"}, FAIL, e_fail);
    check({name, " fail_addr"}, FAIL_ADDR, e_addr);
    check({name, " fail_count"}, FAIL_COUNT, 64'(e_cnt));
    repeat (3) @(negedge A_CLK);
    check({name, " hold"}, {BUSY, DONE, FAIL, FAIL_ADDR, FAIL_COUNT},
          {1'b0, 1'b1, e_fail, e_addr, FW'(e_cnt)});
  endtask

  initial begin
    A_RST = 1'b1;
    START = 1'b0;
    build_ops();
    for (int i = 0; i < N; i++) mem[i] = {$urandom, $urandom};

    // Reset state, with START held high to show reset wins.
    START = 1'b1;
    repeat (3) @(negedge A_CLK);
    check("reset status", {BUSY, DONE, FAIL, FAIL_ADDR, FAIL_COUNT}, '0);
    check("reset port", {bist.A_BIST_EN, bist.A_BIST_MEN, bist.A_BIST_WEN, bist.A_BIST_REN,
                         bist.A_BIST_ADDR}, '0);
    check("reset din", bist.A_BIST_DIN, '0);
    check("reset bm", bist.A_BIST_BM, '0);
    START = 1'b0;
    A_RST = 1'b0;
    repeat (2) @(negedge A_CLK);
    check("idle", {BUSY, DONE}, 2'b00);

    fault_mode = 0;
    run_test("clean", 0, 1'b1);
    run_test("clean_again", 0, 1'b0);

    fault_mode = 1; fault_addr = 6'h2A; fault_bit = 5; fault_val = 1'b0;
    run_test("sa0", 0, 1'b0);
    check("sa0 spec", {FAIL, FAIL_ADDR, FAIL_COUNT}, {1'b1, 6'h2A, 8'd2});
    run_test("sa0_again", 0, 1'b0);

    fault_mode = 2;
    run_test("inv", 0, 1'b0);
    check("inv spec", {FAIL, FAIL_ADDR, FAIL_COUNT}, {1'b1, 6'h00, 8'd255});
    run_test("inv_abort", 100, 1'b0);

    fault_mode = 0;
    run_test("after_abort", 0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      fault_mode = 1;
      fault_addr = AW'($urandom_range(0, N - 1));
      fault_bit  = $urandom_range(0, DW - 1);
      fault_val  = 1'($urandom_range(0, 1));
      run_test("rand_stuck", 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
